// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/retire stage: opcodes, flag bit
// positions and the command record carried through the command FIFO.
package alu_issue_pkg;

  localparam int ALU_LEN = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  // Bit positions inside the 5-bit {ZF,CF,OF,SF,PF} flag vectors.
  localparam int FLAG_ZF = 4;
  localparam int FLAG_CF = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_PF = 0;

  typedef struct packed {
    logic [3:0]         op;
    logic [ALU_LEN-1:0] a;
    logic [ALU_LEN-1:0] b;
  } alu_cmd_t;

  // Only ADD and SUB produce meaningful carry/overflow.
  function automatic logic op_sets_cf_of(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with flush. Head data is combinational from
// storage and forced to zero while empty so the ALU sees a quiet bus.
module alu_cmd_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around a combinational ALU: queues commands, presents
// the head to the ALU, captures results into a backpressured output slot and
// keeps the architectural flags (PSW) plus a retire counter.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int LEN   = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [LEN-1:0]   in_a,
  input  logic [LEN-1:0]   in_b,
  output logic [3:0]       alu_op,
  output logic [LEN-1:0]   alu_a,
  output logic [LEN-1:0]   alu_b,
  input  logic [LEN-1:0]   alu_f,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             alu_of,
  input  logic             alu_sf,
  input  logic             alu_pf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_f,
  output logic [4:0]       out_flags,
  output logic             out_err,
  output logic [4:0]       psw,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int CMD_W = 4 + 2 * LEN;

  logic [CMD_W-1:0] fifo_din, fifo_dout;
  logic             fifo_empty, fifo_full;
  logic             push, fire, illegal;
  logic [4:0]       alu_flags;

  logic             out_valid_q, out_valid_d;
  logic [LEN-1:0]   out_f_q, out_f_d;
  logic [4:0]       out_flags_q, out_flags_d;
  logic             out_err_q, out_err_d;
  logic [4:0]       psw_q, psw_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign fifo_din = {in_op, in_a, in_b};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  alu_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (fire),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign alu_op = fifo_dout[CMD_W-1 -: 4];
  assign alu_a  = fifo_dout[2*LEN-1 -: LEN];
  assign alu_b  = fifo_dout[LEN-1:0];

  assign fire    = !fifo_empty && (!out_valid_q || out_ready) && !flush;
  assign illegal = alu_op[3];

  always_comb begin
    alu_flags          = '0;
    alu_flags[FLAG_ZF] = alu_zf;
    alu_flags[FLAG_CF] = alu_cf;
    alu_flags[FLAG_OF] = alu_of;
    alu_flags[FLAG_SF] = alu_sf;
    alu_flags[FLAG_PF] = alu_pf;
  end

  // Capture slot, PSW and retire counter next-state logic.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_f_d      = out_f_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    psw_d        = psw_q;
    retire_cnt_d = retire_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      if (illegal) begin
        // ALU output for an illegal opcode is meaningless; report a clean zero.
        out_f_d     = '0;
        out_flags_d = '0;
        out_err_d   = 1'b1;
      end else begin
        out_f_d          = alu_f;
        out_flags_d      = alu_flags;
        out_err_d        = 1'b0;
        psw_d[FLAG_ZF]   = alu_zf;
        psw_d[FLAG_SF]   = alu_sf;
        psw_d[FLAG_PF]   = alu_pf;
        if (op_sets_cf_of(alu_op)) begin
          psw_d[FLAG_CF] = alu_cf;
          psw_d[FLAG_OF] = alu_of;
        end
        retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result slot and architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_f_q      <= '0;
      out_flags_q  <= '0;
      out_err_q    <= 1'b0;
      psw_q        <= '0;
      retire_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_f_q      <= out_f_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
      psw_q        <= psw_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_f      = out_f_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;
  assign psw        = psw_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the issue pins.
module tb_alu_issue_stage;

  localparam int LEN   = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready;
  logic [3:0]       in_op, alu_op;
  logic [LEN-1:0]   in_a, in_b, alu_a, alu_b, alu_f, out_f;
  logic             alu_zf, alu_cf, alu_of, alu_sf, alu_pf;
  logic             out_valid, out_ready, out_err;
  logic [4:0]       out_flags, psw;
  logic [CNT_W-1:0] retire_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int acc;

  always #5 clk = ~clk;

  alu_issue_stage #(.LEN(LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_zf     (alu_zf),
    .alu_cf     (alu_cf),
    .alu_of     (alu_of),
    .alu_sf     (alu_sf),
    .alu_pf     (alu_pf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_flags  (out_flags),
    .out_err    (out_err),
    .psw        (psw),
    .retire_cnt (retire_cnt)
  );

  // Behavioural ALU; PF is even parity of the low byte.
  logic [LEN:0] wide;
  always_comb begin
    wide   = '0;
    alu_f  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    alu_zf = 1'b0;
    alu_sf = 1'b0;
    alu_pf = 1'b0;
    case (alu_op)
      4'b0000: begin
        wide   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f  = wide[LEN-1:0];
        alu_cf = wide[LEN];
        alu_of = (alu_a[LEN-1] == alu_b[LEN-1]) && (alu_f[LEN-1] != alu_a[LEN-1]);
      end
      4'b0001: begin
        wide   = {1'b0, alu_a} - {1'b0, alu_b};
        alu_f  = wide[LEN-1:0];
        alu_cf = wide[LEN];
        alu_of = (alu_a[LEN-1] != alu_b[LEN-1]) && (alu_f[LEN-1] != alu_a[LEN-1]);
      end
      4'b0010: alu_f = alu_a & alu_b;
      4'b0011: alu_f = alu_a | alu_b;
      4'b0100: alu_f = alu_a ^ alu_b;
      4'b0101: alu_f = ~(alu_a | alu_b);
      4'b0110: alu_f = alu_a << alu_b[4:0];
      4'b0111: alu_f = alu_a >> alu_b[4:0];
      default: begin
        alu_f  = 32'hDEAD_BEEF;
        alu_cf = 1'b1;
        alu_of = 1'b1;
      end
    endcase
    alu_zf = (alu_f == '0);
    alu_sf = alu_f[LEN-1];
    alu_pf = ~^alu_f[7:0];
    if (alu_op[3]) begin
      alu_zf = 1'b1;
      alu_pf = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'h0, '0, '0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_psw", 32'(psw), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_out_f", out_f, 32'd0);
    chk("rst_alu_idle", {alu_op, 28'd0} | alu_a | alu_b, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of traffic
    out_ready = 1'b0;
    drive(1'b1, 4'h0, 32'd1, 32'd1); step();
    drive(1'b1, 4'h0, 32'd2, 32'd2); step();
    drive(1'b1, 4'h0, 32'd3, 32'd3); step();
    drive(1'b0, 4'h0, '0, '0);
    chk("mid_out_valid_pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_psw", 32'(psw), 32'd0);
    chk("mid_rst_retire", 32'(retire_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    step(); step();
    chk("mid_rst_no_replay", 32'(out_valid), 32'd0);
    chk("mid_rst_no_retire", 32'(retire_cnt), 32'd0);

    // ADD with carry out and zero result
    drive(1'b1, 4'h0, 32'hFFFF_FFFF, 32'h1); step();
    drive(1'b0, 4'h0, '0, '0);
    chk("add_not_yet_valid", 32'(out_valid), 32'd0);
    chk("add_issue_a", alu_a, 32'hFFFF_FFFF);
    step();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_f", out_f, 32'd0);
    chk("add_flags", 32'(out_flags), 32'b11001);
    chk("add_psw", 32'(psw), 32'b11001);
    chk("add_retire", 32'(retire_cnt), 32'd1);
    step();
    chk("add_drained", 32'(out_valid), 32'd0);

    // SUB with borrow, then AND keeping CF/OF in PSW
    drive(1'b1, 4'h1, 32'd5, 32'd7); step();
    drive(1'b1, 4'h2, 32'hF0, 32'h3C); step();
    drive(1'b0, 4'h0, '0, '0);
    chk("sub_f", out_f, 32'hFFFF_FFFE);
    chk("sub_flags", 32'(out_flags), 32'b01010);
    chk("sub_psw", 32'(psw), 32'b01010);
    step();
    chk("and_f", out_f, 32'h30);
    chk("and_flags", 32'(out_flags), 32'b00001);
    chk("and_psw", 32'(psw), 32'b01001);
    chk("and_retire", 32'(retire_cnt), 32'd3);
    step();

    // Backpressure: DEPTH+1 accepted while the slot is blocked
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'h0, 32'(i + 1), 32'h10);
      if (in_ready) acc++;
      step();
    end
    drive(1'b0, 4'h0, '0, '0);
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_slot_held", out_f, 32'h11);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_drain_valid", 32'(out_valid), 32'd1);
      chk("bp_drain_f", out_f, 32'h12 + 32'(i));
    end
    step();
    chk("bp_drain_empty", 32'(out_valid), 32'd0);
    chk("bp_retire", 32'(retire_cnt), 32'd8);

    // Illegal opcode between two ADDs
    drive(1'b1, 4'h0, 32'h7FFF_FFFF, 32'h1); step();
    drive(1'b1, 4'h8, 32'd3, 32'd4); step();
    chk("ill_add1_flags", 32'(out_flags), 32'b00111);
    chk("ill_add1_psw", 32'(psw), 32'b00111);
    drive(1'b1, 4'h0, 32'd1, 32'd2); step();
    drive(1'b0, 4'h0, '0, '0);
    chk("ill_err", 32'(out_err), 32'd1);
    chk("ill_f", out_f, 32'd0);
    chk("ill_flags", 32'(out_flags), 32'd0);
    chk("ill_psw_kept", 32'(psw), 32'b00111);
    chk("ill_retire_kept", 32'(retire_cnt), 32'd9);
    step();
    chk("ill_add2_err", 32'(out_err), 32'd0);
    chk("ill_add2_f", out_f, 32'd3);
    chk("ill_add2_psw", 32'(psw), 32'b00001);
    chk("ill_retire", 32'(retire_cnt), 32'd10);
    step();

    // Flush with full slot, three queued and a same-cycle command
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 32'd3, 32'd10); step();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 4'h3, 32'h100 * 32'(i), 32'h1); step();
    end
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    chk("fl_pre_psw", 32'(psw), 32'b01011);
    chk("fl_pre_retire", 32'(retire_cnt), 32'd11);
    chk("fl_pre_head", alu_a, 32'h100);
    drive(1'b1, 4'h0, 32'h55, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 4'h0, '0, '0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_fifo_empty", alu_a, 32'd0);
    chk("fl_psw", 32'(psw), 32'b01011);
    chk("fl_retire", 32'(retire_cnt), 32'd11);
    out_ready = 1'b1;
    step(); step(); step();
    chk("fl_nothing_after", 32'(out_valid), 32'd0);
    chk("fl_retire_after", 32'(retire_cnt), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
